// File: rtl/seq_player.sv
// Sequence player: reads len entries from the 2-bit sequence memory and shows
// each colour on a one-hot LED bus for ON_CYCLES, dark for OFF_CYCLES, then pulses done.
module seq_player #(
  parameter int unsigned MAX_LEN    = 10,
  parameter int unsigned ON_CYCLES  = 25,
  parameter int unsigned OFF_CYCLES = 10
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] len,
  input  logic [1:0] mem_data,
  output logic [3:0] mem_addr,
  output logic       mem_rw,
  output logic [3:0] led,
  output logic       busy,
  output logic       done
);

  localparam int unsigned T_MAX = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int unsigned TW    = $clog2(T_MAX + 1);
  localparam logic [TW-1:0] ON_LD  = TW'(ON_CYCLES);
  localparam logic [TW-1:0] OFF_LD = TW'(OFF_CYCLES);
  localparam logic [3:0]    MAX_N  = 4'(MAX_LEN);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_SHOW,
    S_GAP,
    S_DONE
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [3:0]    r_n;
  logic [3:0]    r_idx;
  logic [3:0]    r_addr;
  logic [1:0]    r_colour;
  logic [TW-1:0] r_timer;
  logic [3:0]    w_len_clamp;
  logic          w_timer_last;
  logic          w_last_entry;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_len_clamp  = (len > MAX_N) ? MAX_N : len;
    w_timer_last = (r_timer == TW'(1));
    w_last_entry = (r_idx == (r_n - 4'd1));
    led          = '0;
    busy         = 1'b1;
    done         = 1'b0;
    mem_rw       = 1'b0;
    mem_addr     = r_addr;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) w_state_nxt = (w_len_clamp == '0) ? S_DONE : S_FETCH;
      end
      S_FETCH: w_state_nxt = S_WAIT;
      S_WAIT:  w_state_nxt = S_SHOW;
      S_SHOW: begin
        led = 4'b0001 << r_colour;
        if (w_timer_last) w_state_nxt = S_GAP;
      end
      S_GAP: begin
        if (w_timer_last) w_state_nxt = w_last_entry ? S_DONE : S_FETCH;
      end
      S_DONE: begin
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Address is advanced on the way into FETCH so it is already stable while
  // the memory samples it; it then holds until the next entry.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_n      <= '0;
      r_idx    <= '0;
      r_addr   <= '0;
      r_colour <= '0;
      r_timer  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_n    <= w_len_clamp;
            r_idx  <= '0;
            r_addr <= '0;
          end
        end
        S_WAIT: begin
          r_colour <= mem_data;
          r_timer  <= ON_LD;
        end
        S_SHOW: begin
          if (w_timer_last) r_timer <= OFF_LD;
          else              r_timer <= r_timer - TW'(1);
        end
        S_GAP: begin
          if (w_timer_last) begin
            if (!w_last_entry) begin
              r_idx  <= r_idx + 4'd1;
              r_addr <= r_idx + 4'd1;
            end
          end else begin
            r_timer <= r_timer - TW'(1);
          end
        end
        S_DONE: r_addr <= '0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_player.sv
// Bench for seq_player: table-driven and random playbacks checked cycle by cycle
// against a trace built from the playback rules, plus abort/restart corner cases.
module tb_seq_player;

  localparam int ON   = 4;
  localparam int OFF  = 2;
  localparam int MAXL = 10;
  localparam int PER  = 2 + ON + OFF;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic [3:0] len;
  logic [1:0] mem_data;
  logic [3:0] mem_addr;
  logic       mem_rw;
  logic [3:0] led;
  logic       busy;
  logic       done;

  logic [1:0] mem [16];

  seq_player #(.MAX_LEN(MAXL), .ON_CYCLES(ON), .OFF_CYCLES(OFF)) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .len      (len),
    .mem_data (mem_data),
    .mem_addr (mem_addr),
    .mem_rw   (mem_rw),
    .led      (led),
    .busy     (busy),
    .done     (done)
  );

  always #5 clock = ~clock;

  // sequence memory: 1-cycle registered read
  always @(posedge clock) mem_data <= mem[mem_addr];

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [3:0] led;
    logic       busy;
    logic       done;
    logic [3:0] addr;
  } exp_t;

  exp_t q[$];

  typedef struct {
    int len_in;
    int exp_done;
  } tv_t;

  tv_t tab[6];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Expected per-cycle outputs for one playback of n entries, starting in the
  // cycle after start is sampled, ending with the done cycle and one idle cycle.
  function automatic void build(input int n);
    exp_t e;
    q.delete();
    for (int i = 0; i < n; i++) begin
      for (int c = 0; c < PER; c++) begin
        e.led  = (c >= 2 && c < 2 + ON) ? (4'b0001 << mem[i]) : 4'b0000;
        e.busy = 1'b1;
        e.done = 1'b0;
        e.addr = 4'(i);
        q.push_back(e);
      end
    end
    e.led  = '0;
    e.busy = 1'b1;
    e.done = 1'b1;
    e.addr = (n > 0) ? 4'(n - 1) : 4'd0;
    q.push_back(e);
    e.busy = 1'b0;
    e.done = 1'b0;
    e.addr = '0;
    q.push_back(e);
  endfunction

  task automatic check_cycle(input int k);
    chk($sformatf("led[%0d]", k),  32'(led),    32'(q[k].led));
    chk($sformatf("busy[%0d]", k), 32'(busy),   32'(q[k].busy));
    chk($sformatf("done[%0d]", k), 32'(done),   32'(q[k].done));
    chk($sformatf("addr[%0d]", k), 32'(mem_addr), 32'(q[k].addr));
    chk($sformatf("rw[%0d]", k),   32'(mem_rw), 32'd0);
  endtask

  task automatic play(input int len_in, input bit disturb, output int done_edge);
    int n;
    n = (len_in > MAXL) ? MAXL : len_in;
    build(n);
    len   = 4'(len_in);
    start = 1'b1;
    tick();
    start = 1'b0;
    done_edge = -1;
    for (int k = 0; k < q.size(); k++) begin
      check_cycle(k);
      if (done === 1'b1 && done_edge < 0) done_edge = k;
      if (disturb && k == PER + 3) begin
        start  = 1'b1;
        len    = 4'd1;
        mem[1] = ~mem[1];
      end else if (disturb && k == PER + 4) begin
        start = 1'b0;
      end
      tick();
    end
  endtask

  initial begin
    int de;
    int n;
    reset = 1'b1;
    start = 1'b0;
    len   = '0;
    for (int i = 0; i < 16; i++) mem[i] = 2'($urandom_range(0, 3));
    tick();
    tick();
    chk("rst_led",  32'(led), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_rw",   32'(mem_rw), 32'd0);
    reset = 1'b0;
    tick();

    tab[0] = '{3, 24};
    tab[1] = '{0, 0};
    tab[2] = '{15, 80};
    tab[3] = '{10, 80};
    tab[4] = '{1, 8};
    tab[5] = '{11, 80};

    mem[0] = 2'd2;
    mem[1] = 2'd0;
    mem[2] = 2'd3;
    for (int t = 0; t < 6; t++) begin
      play(tab[t].len_in, 1'b0, de);
      chk($sformatf("done_edge_len%0d", tab[t].len_in), 32'(de), 32'(tab[t].exp_done));
    end

    for (int r = 0; r < 8; r++) begin
      int l;
      for (int i = 0; i < 16; i++) mem[i] = 2'($urandom_range(0, 3));
      l = $urandom_range(0, 15);
      n = (l > MAXL) ? MAXL : l;
      play(l, 1'b0, de);
      chk($sformatf("rand_done_edge_len%0d", l), 32'(de), 32'(n * PER));
    end

    // start pulse, len change and memory change during the second SHOW
    mem[0] = 2'd1;
    mem[1] = 2'd3;
    mem[2] = 2'd0;
    play(3, 1'b1, de);
    chk("disturb_done_edge", 32'(de), 32'(3 * PER));

    // reset during the second SHOW aborts at once
    mem[0] = 2'd2;
    mem[1] = 2'd1;
    mem[2] = 2'd3;
    len   = 4'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < PER + 3; k++) tick();
    chk("pre_rst_led", 32'(led), 32'b0010);
    #2;
    reset = 1'b1;
    #1;
    chk("abort_led",  32'(led), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_addr", 32'(mem_addr), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    tick();
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("post_rst_done", 32'(done), 32'd0);
      chk("post_rst_busy", 32'(busy), 32'd0);
    end
    play(3, 1'b0, de);
    chk("restart_done_edge", 32'(de), 32'(3 * PER));

    // start held high: back-to-back single-entry runs
    mem[0] = 2'd3;
    build(1);
    len   = 4'd1;
    start = 1'b1;
    tick();
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < q.size(); k++) begin
        check_cycle(k);
        if (r == 2 && k == q.size() - 1) start = 1'b0;
        tick();
      end
    end
    chk("held_end_busy", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
